// File: rtl/gpr_wb_arbiter_if.sv
// GPR write-port bus: pipeline writeback and mult/div result in, GPR write port,
// hazard report and stall request out.
interface gpr_wb_arbiter_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic             pipe_valid;
  logic             pipe_we;
  logic [AW-1:0]    pipe_wsel;
  logic [DW-1:0]    pipe_wdata;
  logic             md_valid;
  logic [AW-1:0]    md_wsel;
  logic [DW-1:0]    md_wdata;
  logic             md_ready;
  logic             WE;
  logic [AW-1:0]    WeSel;
  logic [DW-1:0]    WData;
  logic             pend_valid;
  logic [AW-1:0]    pend_sel;
  logic             stall_req;
  logic [CNT_W-1:0] coll_cnt;

  modport slave (
    input  pipe_valid, pipe_we, pipe_wsel, pipe_wdata,
    input  md_valid, md_wsel, md_wdata,
    output md_ready, WE, WeSel, WData, pend_valid, pend_sel, stall_req, coll_cnt
  );

  modport master (
    output pipe_valid, pipe_we, pipe_wsel, pipe_wdata,
    output md_valid, md_wsel, md_wdata,
    input  md_ready, WE, WeSel, WData, pend_valid, pend_sel, stall_req, coll_cnt
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Merges pipeline writeback and mult/div results onto the single GPR write port,
// holding one MD result when the pipeline owns the port.
module gpr_wb_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  gpr_wb_arbiter_if.slave  bus
);
  localparam int unsigned SW = $clog2(STARVE_MAX) + 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);

  logic             we_q, we_d;
  logic [AW-1:0]    wesel_q, wesel_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             buf_full_q, buf_full_d;
  logic [AW-1:0]    buf_sel_q, buf_sel_d;
  logic [DW-1:0]    buf_data_q, buf_data_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;
  logic [CNT_W-1:0] coll_q, coll_d;

  logic pw, md_acc, waw;

  always_comb begin
    pw     = bus.pipe_valid & bus.pipe_we;
    md_acc = bus.md_valid & ~buf_full_q;
    waw    = buf_full_q & (bus.pipe_wsel == buf_sel_q);

    we_d       = 1'b0;
    wesel_d    = wesel_q;
    wdata_d    = wdata_q;
    buf_full_d = buf_full_q;
    buf_sel_d  = buf_sel_q;
    buf_data_d = buf_data_q;

    if (pw) begin
      if (bus.pipe_wsel != '0) begin
        we_d    = 1'b1;
        wesel_d = bus.pipe_wsel;
        wdata_d = bus.pipe_wdata;
      end
      // Pipeline result is younger than any MD result to the same register
      if (waw) begin
        buf_full_d = 1'b0;
      end else if (md_acc && (bus.md_wsel != '0) && (bus.md_wsel != bus.pipe_wsel)) begin
        buf_full_d = 1'b1;
        buf_sel_d  = bus.md_wsel;
        buf_data_d = bus.md_wdata;
      end
    end else if (buf_full_q) begin
      we_d       = 1'b1;
      wesel_d    = buf_sel_q;
      wdata_d    = buf_data_q;
      buf_full_d = 1'b0;
    end else if (bus.md_valid && (bus.md_wsel != '0)) begin
      we_d    = 1'b1;
      wesel_d = bus.md_wsel;
      wdata_d = bus.md_wdata;
    end

    if (!buf_full_d) begin
      buf_sel_d = '0;
    end

    coll_d = coll_q;
    if (pw && (buf_full_q || md_acc) && (coll_q != '1)) begin
      coll_d = coll_q + CNT_W'(1);
    end

    starve_d = starve_q;
    if (!buf_full_d) begin
      starve_d = '0;
    end else if (pw && buf_full_q && (starve_q != '1)) begin
      starve_d = starve_q + SW'(1);
    end

    stall_d = pw & buf_full_q & (starve_q >= STARVE_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      wesel_q    <= '0;
      wdata_q    <= '0;
      buf_full_q <= 1'b0;
      buf_sel_q  <= '0;
      buf_data_q <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      coll_q     <= '0;
    end else begin
      we_q       <= we_d;
      wesel_q    <= wesel_d;
      wdata_q    <= wdata_d;
      buf_full_q <= buf_full_d;
      buf_sel_q  <= buf_sel_d;
      buf_data_q <= buf_data_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      coll_q     <= coll_d;
    end
  end

  assign bus.md_ready   = ~buf_full_q;
  assign bus.WE         = we_q;
  assign bus.WeSel      = wesel_q;
  assign bus.WData      = wdata_q;
  assign bus.pend_valid = buf_full_q;
  assign bus.pend_sel   = buf_sel_q;
  assign bus.stall_req  = stall_q;
  assign bus.coll_cnt   = coll_q;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations for the documented scenarios.
module tb_gpr_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SMAX = 4;
  localparam int CW = 4;
  localparam int COLL_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpr_wb_arbiter_if #(.DW(DW), .AW(AW), .CNT_W(CW)) bus ();
  gpr_wb_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SMAX), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: MD holding buffer as a queue of at most one entry
  typedef struct { logic [AW-1:0] sel; logic [DW-1:0] data; } ent_t;
  ent_t      mq[$];
  logic          m_we = 1'b0;
  logic [AW-1:0] m_sel = '0;
  logic [DW-1:0] m_data = '0;
  int            m_coll = 0;
  int            m_starve = 0;
  logic          m_stall = 1'b0;
  bit            m_pw, m_full, m_acc;

  function automatic void m_write(logic [AW-1:0] s, logic [DW-1:0] d);
    if (s != 0) begin
      m_we = 1'b1;
      m_sel = s;
      m_data = d;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_we = 1'b0; m_sel = '0; m_data = '0;
      mq.delete(); m_coll = 0; m_starve = 0; m_stall = 1'b0;
    end else begin
      m_pw   = bus.pipe_valid && bus.pipe_we;
      m_full = mq.size() != 0;
      m_acc  = bus.md_valid && !m_full;
      if (m_pw && (m_full || m_acc) && m_coll < COLL_MAX) m_coll++;
      m_stall = m_pw && m_full && (m_starve >= SMAX - 1);
      m_we = 1'b0;
      if (m_pw) begin
        m_write(bus.pipe_wsel, bus.pipe_wdata);
        if (m_full) begin
          m_starve++;
          if (mq[0].sel == bus.pipe_wsel) mq.delete();
        end else if (m_acc && bus.md_wsel != 0 && bus.md_wsel != bus.pipe_wsel) begin
          mq.push_back('{bus.md_wsel, bus.md_wdata});
        end
      end else if (m_full) begin
        m_write(mq[0].sel, mq[0].data);
        mq.delete();
      end else if (bus.md_valid) begin
        m_write(bus.md_wsel, bus.md_wdata);
      end
      if (mq.size() == 0) m_starve = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_WE", 64'(bus.WE), 64'(m_we));
      chk("m_WeSel", 64'(bus.WeSel), 64'(m_sel));
      chk("m_WData", 64'(bus.WData), 64'(m_data));
      chk("m_pend_valid", 64'(bus.pend_valid), 64'(mq.size() != 0));
      chk("m_pend_sel", 64'(bus.pend_sel), (mq.size() != 0) ? 64'(mq[0].sel) : 64'd0);
      chk("m_md_ready", 64'(bus.md_ready), 64'(mq.size() == 0));
      chk("m_stall_req", 64'(bus.stall_req), 64'(m_stall));
      chk("m_coll_cnt", 64'(bus.coll_cnt), 64'(m_coll));
    end
  end

  task automatic apply(input bit pv, input bit pwe, input logic [AW-1:0] ps, input logic [DW-1:0] pd,
                       input bit mv, input logic [AW-1:0] ms, input logic [DW-1:0] md,
                       input bit r = 1'b0);
    @(posedge clk);
    #1;
    rst = r;
    bus.pipe_valid = pv; bus.pipe_we = pwe; bus.pipe_wsel = ps; bus.pipe_wdata = pd;
    bus.md_valid = mv; bus.md_wsel = ms; bus.md_wdata = md;
  endtask

  task automatic idle(input bit r = 1'b0);
    apply(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, r);
  endtask

  initial begin
    bus.pipe_valid = 1'b0; bus.pipe_we = 1'b0; bus.pipe_wsel = '0; bus.pipe_wdata = '0;
    bus.md_valid = 1'b0; bus.md_wsel = '0; bus.md_wdata = '0;
    idle(1'b1);
    idle(1'b1);
    chk("rst_WE", 64'(bus.WE), 64'd0);
    chk("rst_WeSel", 64'(bus.WeSel), 64'd0);
    chk("rst_WData", 64'(bus.WData), 64'd0);
    chk("rst_pend", 64'(bus.pend_valid), 64'd0);
    chk("rst_coll", 64'(bus.coll_cnt), 64'd0);
    chk("rst_stall", 64'(bus.stall_req), 64'd0);
    chk("rst_md_ready", 64'(bus.md_ready), 64'd1);
    chk_en = 1'b1;

    // Pipeline write appears one cycle later
    apply(1, 1, 5'd5, 32'h11, 0, '0, '0);
    idle();
    chk("pw_WE", 64'(bus.WE), 64'd1);
    chk("pw_WeSel", 64'(bus.WeSel), 64'd5);
    chk("pw_WData", 64'(bus.WData), 64'h11);
    chk("pw_md_ready", 64'(bus.md_ready), 64'd1);

    // MD bypass with empty buffer
    apply(0, 0, '0, '0, 1, 5'd7, 32'hAB);
    idle();
    chk("byp_WeSel", 64'(bus.WeSel), 64'd7);
    chk("byp_WData", 64'(bus.WData), 64'hAB);
    chk("byp_pend", 64'(bus.pend_valid), 64'd0);

    // Collision: MD result buffered, drained on the idle cycle
    apply(1, 1, 5'd3, 32'h33, 1, 5'd9, 32'h55);
    idle();
    chk("col_WeSel1", 64'(bus.WeSel), 64'd3);
    chk("col_pend", 64'(bus.pend_valid), 64'd1);
    chk("col_pend_sel", 64'(bus.pend_sel), 64'd9);
    chk("col_md_ready", 64'(bus.md_ready), 64'd0);
    chk("col_cnt", 64'(bus.coll_cnt), 64'd1);
    idle();
    chk("col_WE2", 64'(bus.WE), 64'd1);
    chk("col_WeSel2", 64'(bus.WeSel), 64'd9);
    chk("col_WData2", 64'(bus.WData), 64'h55);

    // WAW: younger pipeline write to r4 discards buffered r4
    apply(1, 1, 5'd2, 32'h22, 1, 5'd4, 32'h44);
    apply(1, 1, 5'd4, 32'h99, 0, '0, '0);
    idle();
    chk("waw_WeSel", 64'(bus.WeSel), 64'd4);
    chk("waw_WData", 64'(bus.WData), 64'h99);
    chk("waw_pend", 64'(bus.pend_valid), 64'd0);
    idle();
    chk("waw_noWE", 64'(bus.WE), 64'd0);
    chk("waw_coll", 64'(bus.coll_cnt), 64'd3);

    // Starvation: stall_req after the 4th pipeline write against a held result
    apply(1, 1, 5'd1, 32'h1, 1, 5'd6, 32'h66);
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, 5'(10 + i), 32'(i), 0, '0, '0);
      if (i == 3) chk("stv_stall_pre", 64'(bus.stall_req), 64'd0);
    end
    idle();
    chk("stv_stall", 64'(bus.stall_req), 64'd1);
    chk("stv_pend", 64'(bus.pend_valid), 64'd1);
    idle();
    chk("stv_drain_sel", 64'(bus.WeSel), 64'd6);
    chk("stv_stall_clr", 64'(bus.stall_req), 64'd0);
    chk("stv_coll", 64'(bus.coll_cnt), 64'd8);

    // r0 writes are dropped
    apply(1, 1, 5'd0, 32'hDEAD, 0, '0, '0);
    apply(0, 0, '0, '0, 1, 5'd0, 32'hBEEF);
    chk("r0_pipe_WE", 64'(bus.WE), 64'd0);
    idle();
    chk("r0_md_WE", 64'(bus.WE), 64'd0);
    chk("r0_md_ready", 64'(bus.md_ready), 64'd1);

    // Reset with buffer full
    apply(1, 1, 5'd8, 32'h8, 1, 5'd11, 32'hB);
    idle(1'b1);
    chk("mid_pend_pre", 64'(bus.pend_valid), 64'd1);
    idle();
    chk("mid_WE", 64'(bus.WE), 64'd0);
    chk("mid_pend", 64'(bus.pend_valid), 64'd0);
    chk("mid_coll", 64'(bus.coll_cnt), 64'd0);
    chk("mid_md_ready", 64'(bus.md_ready), 64'd1);

    // Collision counter saturates
    apply(1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    for (int i = 0; i < 19; i++) apply(1, 1, 5'd3, 32'(i), 0, '0, '0);
    idle();
    chk("sat_coll", 64'(bus.coll_cnt), 64'(COLL_MAX));
    idle();
    chk("sat_drain_sel", 64'(bus.WeSel), 64'd2);

    // Mixed sweep with small register range to exercise WAW and r0 corners
    for (int i = 0; i < 150; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            32'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 32'($urandom));
    end
    idle();
    idle();
    idle();
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
